// File: rtl/pmem_arbiter_if.sv
// pmem_arbiter_if: bundles the icache miss port, dcache miss port and the
// physical-memory port seen by pmem_arbiter.
//   master : arbiter view (takes client requests and memory replies,
//            drives client responses and the memory command)
//   slave  : environment view (clients + physical memory)
interface pmem_arbiter_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = 128
);
  // icache port
  logic                  i_read;
  logic [ADDR_WIDTH-1:0] i_address;
  logic [LINE_WIDTH-1:0] i_rdata;
  logic                  i_resp;
  // dcache port
  logic                  d_read;
  logic                  d_write;
  logic [ADDR_WIDTH-1:0] d_address;
  logic [LINE_WIDTH-1:0] d_wdata;
  logic [LINE_WIDTH-1:0] d_rdata;
  logic                  d_resp;
  // physical memory port
  logic                  pmem_read;
  logic                  pmem_write;
  logic [ADDR_WIDTH-1:0] pmem_address;
  logic [LINE_WIDTH-1:0] pmem_wdata;
  logic [LINE_WIDTH-1:0] pmem_rdata;
  logic                  pmem_resp;

  modport master (
    input  i_read, i_address,
    output i_rdata, i_resp,
    input  d_read, d_write, d_address, d_wdata,
    output d_rdata, d_resp,
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  pmem_rdata, pmem_resp
  );

  modport slave (
    output i_read, i_address,
    input  i_rdata, i_resp,
    output d_read, d_write, d_address, d_wdata,
    input  d_rdata, d_resp,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pmem_rdata, pmem_resp
  );
endinterface

// File: rtl/pmem_arbiter.sv
// pmem_arbiter: round-robin arbiter between the icache and dcache miss ports
// and the single physical-memory port. One line-sized request is latched,
// held on the memory bus until pmem_resp, and the returned line is handed
// back to the owning client with a one-cycle resp pulse.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - pmem_arbiter_if.master (client ports + memory port)
module pmem_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = 128
) (
  input  logic           clk,
  input  logic           rst,
  pmem_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;
  typedef enum logic {CL_I, CL_D} client_e;

  state_e                state_q;
  client_e               owner_q, last_q;
  logic                  cmd_rd_q, cmd_wr_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LINE_WIDTH-1:0] wdata_q, rdata_q;
  logic                  i_resp_q, d_resp_q;

  // Values latched on a grant in IDLE
  logic                  req_i, req_d, pick_d;
  client_e               owner_d;
  logic                  cmd_rd_d, cmd_wr_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [LINE_WIDTH-1:0] wdata_d;

  always_comb begin
    req_i    = bus.i_read;
    req_d    = bus.d_read | bus.d_write;
    // dcache wins when alone, or on a tie when icache was served last
    pick_d   = req_d & (~req_i | (last_q == CL_I));
    owner_d  = pick_d ? CL_D : CL_I;
    // read+write together from the dcache is treated as a write-back
    cmd_wr_d = pick_d & bus.d_write;
    cmd_rd_d = pick_d ? (bus.d_read & ~bus.d_write) : 1'b1;
    addr_d   = pick_d ? bus.d_address : bus.i_address;
    wdata_d  = pick_d ? bus.d_wdata : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= CL_I;
      last_q   <= CL_I;
      cmd_rd_q <= 1'b0;
      cmd_wr_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      i_resp_q <= 1'b0;
      d_resp_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_i | req_d) begin
            owner_q  <= owner_d;
            cmd_rd_q <= cmd_rd_d;
            cmd_wr_q <= cmd_wr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            state_q  <= BUSY;
          end
        end
        BUSY: begin
          // command registers double as the memory bus drivers; they
          // drop together with the transition to RESP
          if (bus.pmem_resp) begin
            rdata_q  <= bus.pmem_rdata;
            last_q   <= owner_q;
            cmd_rd_q <= 1'b0;
            cmd_wr_q <= 1'b0;
            i_resp_q <= (owner_q == CL_I);
            d_resp_q <= (owner_q == CL_D);
            state_q  <= RESP;
          end
        end
        RESP: begin
          // one idle edge lets the client drop its request before re-arbitration
          i_resp_q <= 1'b0;
          d_resp_q <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.pmem_read    = cmd_rd_q;
  assign bus.pmem_write   = cmd_wr_q;
  assign bus.pmem_address = addr_q;
  assign bus.pmem_wdata   = wdata_q;
  assign bus.i_rdata      = rdata_q;
  assign bus.d_rdata      = rdata_q;
  assign bus.i_resp       = i_resp_q;
  assign bus.d_resp       = d_resp_q;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed bench for pmem_arbiter: inputs change 1ns after a rising edge,
// outputs are checked at that same point (settled after the edge).
module tb_pmem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  pmem_arbiter_if bus ();

  pmem_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  localparam logic [127:0] LINE_DB = {16'hDEAD, 96'h0123_4567_89AB_CDEF_0123_4567, 16'hBEEF};
  localparam logic [127:0] LINE_A5 = {16{8'hA5}};
  localparam logic [127:0] LINE_R1 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [127:0] LINE_R2 = 128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // memory command + both resps in one call
  task automatic chk_bus(input string tag, input logic rd, input logic wr,
                         input logic ir, input logic dr);
    chk({tag, ".pmem_read"},  {127'd0, bus.pmem_read},  {127'd0, rd});
    chk({tag, ".pmem_write"}, {127'd0, bus.pmem_write}, {127'd0, wr});
    chk({tag, ".i_resp"},     {127'd0, bus.i_resp},     {127'd0, ir});
    chk({tag, ".d_resp"},     {127'd0, bus.d_resp},     {127'd0, dr});
  endtask

  logic [15:0] exp_addr [4];
  logic        exp_isd  [4];

  initial begin
    bus.i_read = 0; bus.i_address = '0;
    bus.d_read = 0; bus.d_write = 0; bus.d_address = '0; bus.d_wdata = '0;
    bus.pmem_rdata = '0; bus.pmem_resp = 0;

    // ---- reset state
    step(); step();
    rst = 0;
    chk_bus("reset", 0, 0, 0, 0);
    chk("reset.pmem_address", {112'd0, bus.pmem_address}, 128'd0);
    chk("reset.pmem_wdata", bus.pmem_wdata, 128'd0);
    chk("reset.i_rdata", bus.i_rdata, 128'd0);
    chk("reset.d_rdata", bus.d_rdata, 128'd0);

    // ---- icache read of 0x0040, memory waits one extra cycle
    bus.i_read = 1; bus.i_address = 16'h0040;
    step();
    chk_bus("irdA", 1, 0, 0, 0);
    chk("irdA.addr", {112'd0, bus.pmem_address}, 128'h0040);
    step();
    chk_bus("irdB", 1, 0, 0, 0);
    bus.pmem_resp = 1; bus.pmem_rdata = LINE_DB;
    step();
    chk_bus("irdC", 0, 0, 1, 0);
    chk("irdC.i_rdata", bus.i_rdata, LINE_DB);
    bus.i_read = 0; bus.pmem_resp = 0; bus.pmem_rdata = '0;
    step();
    chk_bus("irdD", 0, 0, 0, 0);

    // ---- stray pmem_resp in IDLE is ignored
    bus.pmem_resp = 1;
    step();
    chk_bus("stray", 0, 0, 0, 0);
    bus.pmem_resp = 0;
    step();

    // ---- dcache write-back to 0x1230, inputs changed mid-BUSY
    bus.d_write = 1; bus.d_address = 16'h1230; bus.d_wdata = LINE_A5;
    step();
    chk_bus("dwrA", 0, 1, 0, 0);
    chk("dwrA.addr", {112'd0, bus.pmem_address}, 128'h1230);
    chk("dwrA.wdata", bus.pmem_wdata, LINE_A5);
    bus.d_address = 16'hFFFF; bus.d_wdata = '0;
    step();
    chk_bus("dwrB", 0, 1, 0, 0);
    chk("dwrB.addr_held", {112'd0, bus.pmem_address}, 128'h1230);
    chk("dwrB.wdata_held", bus.pmem_wdata, LINE_A5);
    bus.pmem_resp = 1; bus.pmem_rdata = LINE_R1;
    step();
    chk_bus("dwrC", 0, 0, 0, 1);
    bus.d_write = 0; bus.pmem_resp = 0;
    step();
    chk_bus("dwrD", 0, 0, 0, 0);

    // ---- simultaneous requests out of reset: D first, then I
    rst = 1;
    bus.i_read = 1; bus.i_address = 16'h0100;
    bus.d_read = 1; bus.d_address = 16'h0200;
    step();
    rst = 0;
    chk_bus("tie.rst", 0, 0, 0, 0);
    step();
    chk_bus("tieA", 1, 0, 0, 0);
    chk("tieA.addr", {112'd0, bus.pmem_address}, 128'h0200);
    bus.pmem_resp = 1; bus.pmem_rdata = LINE_R1;
    step();
    chk_bus("tieB", 0, 0, 0, 1);
    chk("tieB.d_rdata", bus.d_rdata, LINE_R1);
    bus.d_read = 0; bus.pmem_resp = 0;
    step();
    chk_bus("tieC", 0, 0, 0, 0);
    step();
    chk_bus("tieD", 1, 0, 0, 0);
    chk("tieD.addr", {112'd0, bus.pmem_address}, 128'h0100);
    bus.pmem_resp = 1; bus.pmem_rdata = LINE_R2;
    step();
    chk_bus("tieE", 0, 0, 1, 0);
    chk("tieE.i_rdata", bus.i_rdata, LINE_R2);
    bus.i_read = 0; bus.pmem_resp = 0;
    step();

    // ---- sustained contention: D, I, D, I (I was served last)
    exp_addr[0] = 16'h0200; exp_isd[0] = 1;
    exp_addr[1] = 16'h0100; exp_isd[1] = 0;
    exp_addr[2] = 16'h0200; exp_isd[2] = 1;
    exp_addr[3] = 16'h0100; exp_isd[3] = 0;
    bus.i_read = 1; bus.d_read = 1;
    for (int t = 0; t < 4; t++) begin
      step();
      chk($sformatf("rr%0d.grant", t), {127'd0, bus.pmem_read}, 128'd1);
      chk($sformatf("rr%0d.addr", t), {112'd0, bus.pmem_address}, {112'd0, exp_addr[t]});
      bus.pmem_resp = 1;
      step();
      chk_bus($sformatf("rr%0d.resp", t), 0, 0, !exp_isd[t], exp_isd[t]);
      bus.pmem_resp = 0;
      step();
      chk_bus($sformatf("rr%0d.idle", t), 0, 0, 0, 0);
    end
    bus.i_read = 0; bus.d_read = 0;
    step();

    // ---- illegal d_read+d_write is issued as a write
    bus.d_read = 1; bus.d_write = 1; bus.d_address = 16'h0300;
    step();
    chk_bus("rw", 0, 1, 0, 0);
    chk("rw.addr", {112'd0, bus.pmem_address}, 128'h0300);
    bus.pmem_resp = 1;
    step();
    chk_bus("rwB", 0, 0, 0, 1);
    bus.d_read = 0; bus.d_write = 0; bus.pmem_resp = 0;
    step();

    // ---- reset during BUSY, then a late pmem_resp
    bus.i_read = 1; bus.i_address = 16'h0500;
    step();
    chk_bus("abortA", 1, 0, 0, 0);
    rst = 1;
    step();
    chk_bus("abortB", 0, 0, 0, 0);
    chk("abortB.addr", {112'd0, bus.pmem_address}, 128'd0);
    chk("abortB.wdata", bus.pmem_wdata, 128'd0);
    rst = 0; bus.i_read = 0; bus.pmem_resp = 1; bus.pmem_rdata = LINE_R2;
    step();
    chk_bus("abortC", 0, 0, 0, 0);
    chk("abortC.rdata", bus.i_rdata, 128'd0);
    bus.pmem_resp = 0;
    step();
    chk_bus("abortD", 0, 0, 0, 0);
    // still in IDLE: a fresh request is granted on the next edge
    bus.d_read = 1; bus.d_address = 16'h0600;
    step();
    chk_bus("abortE", 1, 0, 0, 0);
    chk("abortE.addr", {112'd0, bus.pmem_address}, 128'h0600);
    bus.pmem_resp = 1;
    step();
    chk_bus("abortF", 0, 0, 0, 1);
    bus.d_read = 0; bus.pmem_resp = 0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
